// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
// Holds opcode constants, instruction field positions, the controller state enum,
// operand-forward select encodings and the per-instruction dest/source helpers.
package hazard_pkg;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpAdi  = 4'b0001;
  localparam logic [3:0] OpNand = 4'b0010;
  localparam logic [3:0] OpLhi  = 4'b0011;
  localparam logic [3:0] OpLw   = 4'b0100;
  localparam logic [3:0] OpSw   = 4'b0101;
  localparam logic [3:0] OpJal  = 4'b1000;
  localparam logic [3:0] OpJlr  = 4'b1001;
  localparam logic [3:0] OpBeq  = 4'b1100;

  localparam int unsigned OpMsb = 15;
  localparam int unsigned OpLsb = 12;
  localparam int unsigned RaMsb = 11;
  localparam int unsigned RaLsb = 9;
  localparam int unsigned RbMsb = 8;
  localparam int unsigned RbLsb = 6;
  localparam int unsigned RcMsb = 5;
  localparam int unsigned RcLsb = 3;

  typedef enum logic [1:0] {StRun, StLdUse, StFlush, StMemWait} state_e;

  localparam logic [1:0] FwdRf  = 2'd0;
  localparam logic [1:0] FwdEx  = 2'd1;
  localparam logic [1:0] FwdMem = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } dest_t;

  // All-zero word is a NOP, not an ADD r0,r0,r0: no source, no destination.
  function automatic dest_t dest_of(input logic [15:0] ins);
    dest_t d;
    d.vld = 1'b0;
    d.idx = 3'd0;
    if (ins != 16'd0) begin
      case (ins[OpMsb:OpLsb])
        OpAdd, OpNand: begin
          d.vld = 1'b1;
          d.idx = ins[RcMsb:RcLsb];
        end
        OpAdi: begin
          d.vld = 1'b1;
          d.idx = ins[RbMsb:RbLsb];
        end
        OpLhi, OpLw, OpJal, OpJlr: begin
          d.vld = 1'b1;
          d.idx = ins[RaMsb:RaLsb];
        end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic uses_ra(input logic [15:0] ins);
    logic r;
    r = 1'b0;
    if (ins != 16'd0) begin
      case (ins[OpMsb:OpLsb])
        OpAdd, OpNand, OpBeq, OpAdi, OpSw: r = 1'b1;
        default:                           r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic uses_rb(input logic [15:0] ins);
    logic r;
    r = 1'b0;
    if (ins != 16'd0) begin
      case (ins[OpMsb:OpLsb])
        OpAdd, OpNand, OpBeq, OpLw, OpSw, OpJlr: r = 1'b1;
        default:                                 r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives stage instructions and status, reads controls).
// slave : hazard controller (reads stage instructions and status, drives controls).
//   id_ins/ex_ins/mem_ins : instructions in decode/execute/memory pipe registers
//   br_taken, mem_busy    : branch resolved taken, data memory not done
//   stall_if, stall_id, dhazard, flush_id : pipe register controls
//   fwd_a, fwd_b          : operand forward selects
//   stall_cnt             : saturating bubble/stall cycle counter
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [15:0]      id_ins;
  logic [15:0]      ex_ins;
  logic [15:0]      mem_ins;
  logic             br_taken;
  logic             mem_busy;
  logic             stall_if;
  logic             stall_id;
  logic             dhazard;
  logic             flush_id;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_ins, ex_ins, mem_ins, br_taken, mem_busy,
    input  stall_if, stall_id, dhazard, flush_id, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_ins, ex_ins, mem_ins, br_taken, mem_busy,
    output stall_if, stall_id, dhazard, flush_id, fwd_a, fwd_b, stall_cnt
  );

endinterface

// File: rtl/hazard_decode.sv
// hazard_decode: combinational register-usage extraction for one pipe stage.
// Ports:
//   i_ins      : stage instruction
//   o_dst_vld  : instruction writes a register
//   o_dst      : destination register index
//   o_ra_use   : instruction reads the ra field
//   o_ra       : ra field
//   o_rb_use   : instruction reads the rb field
//   o_rb       : rb field
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [15:0] i_ins,
  output logic        o_dst_vld,
  output logic [2:0]  o_dst,
  output logic        o_ra_use,
  output logic [2:0]  o_ra,
  output logic        o_rb_use,
  output logic [2:0]  o_rb
);

  dest_t w_dest;

  assign w_dest    = dest_of(i_ins);
  assign o_dst_vld = w_dest.vld;
  assign o_dst     = w_dest.idx;
  assign o_ra_use  = uses_ra(i_ins);
  assign o_ra      = i_ins[RaMsb:RaLsb];
  assign o_rb_use  = uses_rb(i_ins);
  assign o_rb      = i_ins[RbMsb:RbLsb];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 16-bit RISC core.
// Detects RAW, load-use, taken-branch and memory-wait hazards and drives the
// stall/bubble/flush controls combinationally (Mealy); keeps a saturating
// count of bubble cycles.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : hazard_ctrl_if.slave (stage instructions, status, controls, counter)
// Parameters:
//   CNT_W     : stall counter width
//   FLUSH_CYC : bubbles per taken branch, 1..3
// Build option:
//   HAZARD_FORWARD_EN : enables operand forwarding; only load-use then stalls.
//                       Without it every RAW on ex/mem stalls and fwd_a/fwd_b are 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYC - 1);

  logic       w_id_dst_vld, w_id_ra_use, w_id_rb_use;
  logic [2:0] w_id_dst, w_id_ra, w_id_rb;
  logic       w_ex_dst_vld, w_ex_ra_use, w_ex_rb_use;
  logic [2:0] w_ex_dst, w_ex_ra, w_ex_rb;
  logic       w_mem_dst_vld, w_mem_ra_use, w_mem_rb_use;
  logic [2:0] w_mem_dst, w_mem_ra, w_mem_rb;
  logic       w_unused;

  hazard_decode u_dec_id (
    .i_ins     (bus.id_ins),
    .o_dst_vld (w_id_dst_vld),
    .o_dst     (w_id_dst),
    .o_ra_use  (w_id_ra_use),
    .o_ra      (w_id_ra),
    .o_rb_use  (w_id_rb_use),
    .o_rb      (w_id_rb)
  );

  hazard_decode u_dec_ex (
    .i_ins     (bus.ex_ins),
    .o_dst_vld (w_ex_dst_vld),
    .o_dst     (w_ex_dst),
    .o_ra_use  (w_ex_ra_use),
    .o_ra      (w_ex_ra),
    .o_rb_use  (w_ex_rb_use),
    .o_rb      (w_ex_rb)
  );

  hazard_decode u_dec_mem (
    .i_ins     (bus.mem_ins),
    .o_dst_vld (w_mem_dst_vld),
    .o_dst     (w_mem_dst),
    .o_ra_use  (w_mem_ra_use),
    .o_ra      (w_mem_ra),
    .o_rb_use  (w_mem_rb_use),
    .o_rb      (w_mem_rb)
  );

  // Only id sources and ex/mem destinations matter for hazards.
  assign w_unused = ^{w_id_dst_vld, w_id_dst, w_ex_ra_use, w_ex_ra, w_ex_rb_use, w_ex_rb,
                      w_mem_ra_use, w_mem_ra, w_mem_rb_use, w_mem_rb};

  logic w_raw_ex_a, w_raw_ex_b, w_raw_mem_a, w_raw_mem_b;
  logic w_data_haz;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_raw_ex_a  = w_id_ra_use & w_ex_dst_vld  & (w_ex_dst  == w_id_ra);
  assign w_raw_ex_b  = w_id_rb_use & w_ex_dst_vld  & (w_ex_dst  == w_id_rb);
  assign w_raw_mem_a = w_id_ra_use & w_mem_dst_vld & (w_mem_dst == w_id_ra);
  assign w_raw_mem_b = w_id_rb_use & w_mem_dst_vld & (w_mem_dst == w_id_rb);

  state_e     r_state, w_state_nxt;
  logic [1:0] r_flush_cnt, w_flush_nxt;

`ifdef HAZARD_FORWARD_EN
  // The bubble already paid in LdUse lets the load reach forwarding range.
  assign w_data_haz = (r_state != StLdUse) && (bus.ex_ins[OpMsb:OpLsb] == OpLw) &&
                      (w_raw_ex_a || w_raw_ex_b);
  assign w_fwd_a = w_raw_ex_a ? FwdEx : (w_raw_mem_a ? FwdMem : FwdRf);
  assign w_fwd_b = w_raw_ex_b ? FwdEx : (w_raw_mem_b ? FwdMem : FwdRf);
`else
  assign w_data_haz = w_raw_ex_a | w_raw_ex_b | w_raw_mem_a | w_raw_mem_b;
  assign w_fwd_a = FwdRf;
  assign w_fwd_b = FwdRf;
`endif

  logic w_stall_if, w_stall_id, w_dhazard, w_flush_id;

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_dhazard   = 1'b0;
    w_flush_id  = 1'b0;
    if (bus.br_taken) begin
      w_flush_id  = 1'b1;
      w_dhazard   = 1'b1;
      w_flush_nxt = FlushLoad;
      w_state_nxt = (FlushLoad != 2'd0) ? StFlush : StRun;
    end else if (r_state == StFlush) begin
      w_flush_id = 1'b1;
      w_dhazard  = 1'b1;
      if (bus.mem_busy) begin
        // Freeze the remaining bubbles until memory completes.
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
      end else begin
        w_flush_nxt = r_flush_cnt - 2'd1;
        w_state_nxt = (r_flush_cnt <= 2'd1) ? StRun : StFlush;
      end
    end else if (bus.mem_busy) begin
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_dhazard   = 1'b1;
      w_state_nxt = StMemWait;
    end else if (w_data_haz) begin
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_dhazard   = 1'b1;
      w_state_nxt = StLdUse;
    end else begin
      w_state_nxt = StRun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StRun;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
    end
  end

  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_dhazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Gate with reset so outputs drop the instant reset asserts, whatever the inputs.
  assign bus.stall_if  = w_stall_if & reset;
  assign bus.stall_id  = w_stall_id & reset;
  assign bus.dhazard   = w_dhazard & reset;
  assign bus.flush_id  = w_flush_id & reset;
  assign bus.fwd_a     = reset ? w_fwd_a : FwdRf;
  assign bus.fwd_b     = reset ? w_fwd_b : FwdRf;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
